// File: rtl/noc_inject_arbiter.sv
// Injection arbiter: round-robin among local requesters with packet-level locking,
// credit-based flow control toward one mesh endpoint, and registered NoC outputs.
module noc_inject_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int FLIT_WIDTH        = 256,
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_BUFFER_DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0][FLIT_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0][DEST_WIDTH-1:0]   req_dest,
  input  logic [NUM_REQ-1:0]                   req_is_tail,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [FLIT_WIDTH-1:0]                noc_data,
  output logic [DEST_WIDTH-1:0]                noc_dest,
  output logic                                 noc_is_tail,
  output logic                                 noc_send,
  input  logic                                 noc_credit,
  output logic                                 cred_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(FLIT_BUFFER_DEPTH);
  localparam logic [IW-1:0] LAST_REQ = IW'(NUM_REQ - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cred_err_q, cred_err_d;
  logic            send_q;
  logic [FLIT_WIDTH-1:0] data_q;
  logic [DEST_WIDTH-1:0] dest_q;
  logic            tail_q;

  logic [IW-1:0]   winner;
  logic            found;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   sel_inc;
  logic            grant_ok;
  logic            xfer;

  // Rotating priority search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [IW:0] sum;
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr_q} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
      if (!found && req_valid[sum[IW-1:0]]) begin
        found  = 1'b1;
        winner = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    sel      = (state_q == LOCKED) ? owner_q : winner;
    sel_inc  = (sel == LAST_REQ) ? '0 : sel + 1'b1;
    grant_ok = ((state_q == LOCKED) || found) && (cnt_q != '0) && !rst;
    req_ready = '0;
    if (grant_ok) req_ready[sel] = 1'b1;
    xfer = grant_ok && req_valid[sel];
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    cred_err_d = cred_err_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (req_is_tail[sel]) begin
            rr_ptr_d = sel_inc;
          end else begin
            state_d = LOCKED;
            owner_d = sel;
          end
        end
      end
      LOCKED: begin
        if (xfer && req_is_tail[sel]) begin
          state_d  = IDLE;
          rr_ptr_d = sel_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    // A credit arriving with the counter already full is dropped and flagged.
    if (xfer && !noc_credit) begin
      cnt_d = cnt_q - 1'b1;
    end else if (!xfer && noc_credit) begin
      if (cnt_q == CRED_MAX) cred_err_d = 1'b1;
      else                   cnt_d      = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= CRED_MAX;
      cred_err_q <= 1'b0;
      send_q     <= 1'b0;
      data_q     <= '0;
      dest_q     <= '0;
      tail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      cred_err_q <= cred_err_d;
      send_q     <= xfer;
      if (xfer) begin
        data_q <= req_data[sel];
        dest_q <= req_dest[sel];
        tail_q <= req_is_tail[sel];
      end
    end
  end

  assign noc_send    = send_q;
  assign noc_data    = data_q;
  assign noc_dest    = dest_q;
  assign noc_is_tail = tail_q;
  assign cred_err    = cred_err_q;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Randomized and directed checks of noc_inject_arbiter against a transaction-level model.
module tb_noc_inject_arbiter;

  localparam int NR    = 4;
  localparam int FW    = 32;
  localparam int DW    = 4;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic [NR-1:0][FW-1:0]    req_data;
  logic [NR-1:0][DW-1:0]    req_dest;
  logic [NR-1:0]            req_is_tail;
  logic [NR-1:0]            req_valid;
  logic [NR-1:0]            req_ready;
  logic [FW-1:0]            noc_data;
  logic [DW-1:0]            noc_dest;
  logic                     noc_is_tail;
  logic                     noc_send;
  logic                     noc_credit;
  logic                     cred_err;

  noc_inject_arbiter #(
    .NUM_REQ(NR),
    .FLIT_WIDTH(FW),
    .DEST_WIDTH(DW),
    .FLIT_BUFFER_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_data(req_data),
    .req_dest(req_dest),
    .req_is_tail(req_is_tail),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .noc_data(noc_data),
    .noc_dest(noc_dest),
    .noc_is_tail(noc_is_tail),
    .noc_send(noc_send),
    .noc_credit(noc_credit),
    .cred_err(cred_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: owner -1 means no packet in progress; credits counted as an int.
  int          m_owner = -1;
  int          m_ptr   = 0;
  int          m_cnt   = DEPTH;
  bit          m_err   = 1'b0;
  logic          m_send = 1'b0;
  logic [FW-1:0] m_data = '0;
  logic [DW-1:0] m_dest = '0;
  logic          m_tail = 1'b0;

  int rem[NR];
  int next_len[NR];
  bit rand_len = 1'b0;
  int grants[$];
  int sent = 0;

  function automatic int gi(input int i);
    return (grants.size() > i) ? grants[i] : -1;
  endfunction

  task automatic cycle(input bit r, input logic [NR-1:0] v, input bit cr);
    logic [NR-1:0] exp_rdy;
    int  sel;
    bit  xfer;
    @(negedge clk);
    rst        = r;
    req_valid  = v;
    noc_credit = cr;
    for (int i = 0; i < NR; i++) begin
      req_data[i]    = $urandom;
      req_dest[i]    = DW'($urandom);
      req_is_tail[i] = (rem[i] == 1);
    end
    #1;
    exp_rdy = '0;
    sel     = -1;
    if (!r) begin
      if (m_owner >= 0) sel = m_owner;
      else
        for (int k = 0; k < NR; k++)
          if (sel < 0 && v[(m_ptr + k) % NR]) sel = (m_ptr + k) % NR;
      if (sel >= 0 && m_cnt > 0) exp_rdy[sel] = 1'b1;
    end
    xfer = (sel >= 0) && exp_rdy[sel] && v[sel];
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    for (int i = 0; i < NR; i++)
      if (req_ready[i] && v[i]) grants.push_back(i);

    if (r) begin
      m_owner = -1; m_ptr = 0; m_cnt = DEPTH; m_err = 1'b0;
      m_send = 1'b0; m_data = '0; m_dest = '0; m_tail = 1'b0;
    end else begin
      if (xfer) begin
        m_send = 1'b1;
        m_data = req_data[sel];
        m_dest = req_dest[sel];
        m_tail = req_is_tail[sel];
        if (req_is_tail[sel]) begin
          m_owner = -1;
          m_ptr   = (sel + 1) % NR;
        end else begin
          m_owner = sel;
        end
        rem[sel]--;
        if (rem[sel] == 0) rem[sel] = rand_len ? int'($urandom_range(1, 4)) : next_len[sel];
      end else begin
        m_send = 1'b0;
      end
      if (cr && !xfer && m_cnt == DEPTH) m_err = 1'b1;
      else m_cnt = m_cnt - (xfer ? 1 : 0) + (cr ? 1 : 0);
    end

    @(posedge clk);
    #1;
    check("noc_send", 64'(noc_send), 64'(m_send));
    check("noc_data", 64'(noc_data), 64'(m_data));
    check("noc_dest", 64'(noc_dest), 64'(m_dest));
    check("noc_is_tail", 64'(noc_is_tail), 64'(m_tail));
    check("cred_err", 64'(cred_err), 64'(m_err));
    if (noc_send === 1'b1) sent++;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; noc_credit = 1'b0;
    req_data = '0; req_dest = '0; req_is_tail = '0;
    for (int i = 0; i < NR; i++) begin rem[i] = 1; next_len[i] = 1; end

    // Reset with all requesters valid: nothing may be granted.
    cycle(1'b1, 4'hF, 1'b0);
    cycle(1'b1, 4'hF, 1'b0);

    // Single-flit packets from 1 and 3, credits every cycle.
    grants.delete(); sent = 0;
    repeat (4) cycle(1'b0, 4'b1010, 1'b1);
    check("rr_g0", 64'(gi(0)), 64'd1);
    check("rr_g1", 64'(gi(1)), 64'd3);
    check("rr_g2", 64'(gi(2)), 64'd1);
    check("rr_g3", 64'(gi(3)), 64'd3);
    check("rr_sent", 64'(sent), 64'd4);

    // 3-flit packet from 0 while 2 is waiting.
    cycle(1'b1, 4'h0, 1'b0);
    rem[0] = 3; next_len[0] = 1; rem[2] = 1;
    grants.delete();
    repeat (5) cycle(1'b0, 4'b0101, 1'b1);
    check("lock_g0", 64'(gi(0)), 64'd0);
    check("lock_g1", 64'(gi(1)), 64'd0);
    check("lock_g2", 64'(gi(2)), 64'd0);
    check("lock_g3", 64'(gi(3)), 64'd2);
    check("lock_g4", 64'(gi(4)), 64'd0);

    // Credit exhaustion, then one credit coinciding with valid.
    cycle(1'b1, 4'h0, 1'b0);
    for (int i = 0; i < NR; i++) rem[i] = 1;
    grants.delete(); sent = 0;
    repeat (4) cycle(1'b0, 4'hF, 1'b0);
    check("cred_sent2", 64'(sent), 64'd2);
    check("cred_grants2", 64'(grants.size()), 64'd2);
    cycle(1'b0, 4'hF, 1'b1);
    check("cred_same_cycle", 64'(grants.size()), 64'd2);
    cycle(1'b0, 4'hF, 1'b0);
    check("cred_next_cycle", 64'(grants.size()), 64'd3);
    check("cred_g2", 64'(gi(2)), 64'd2);
    cycle(1'b0, 4'hF, 1'b0);
    check("cred_sent3", 64'(sent), 64'd3);

    // Credit overflow is sticky until reset.
    cycle(1'b1, 4'h0, 1'b0);
    cycle(1'b0, 4'h0, 1'b1);
    check("ovf_set", 64'(cred_err), 64'd1);
    repeat (3) cycle(1'b0, 4'h0, 1'b0);
    check("ovf_sticky", 64'(cred_err), 64'd1);
    cycle(1'b1, 4'h0, 1'b0);
    check("ovf_cleared", 64'(cred_err), 64'd0);

    // Reset mid-packet abandons the lock; arbitration restarts at 0.
    rem[2] = 4;
    cycle(1'b0, 4'b0100, 1'b0);
    check("mid_head_sent", 64'(noc_send), 64'd1);
    cycle(1'b1, 4'b0101, 1'b1);
    check("mid_rst_send", 64'(noc_send), 64'd0);
    check("mid_rst_data", 64'(noc_data), 64'd0);
    rem[0] = 1;
    grants.delete();
    cycle(1'b0, 4'b0101, 1'b0);
    check("mid_first_grant", 64'(gi(0)), 64'd0);

    // Random traffic with legal credit returns and occasional resets.
    rand_len = 1'b1;
    for (int n = 0; n < 600; n++) begin
      bit r, c;
      r = ($urandom_range(0, 63) == 0);
      c = (m_cnt < DEPTH) && ($urandom_range(0, 1) == 1);
      cycle(r, NR'($urandom), c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
